uart_tx_arbiter: RTL

Frame-safe arbiter that shares the board's single UART TX pin between two serial transmitters: the CPU UART and the DRAM controller's debug UART. It replaces a raw combinational select. The output source changes only when both lines have been idle (mark) for a full character time, so a switch never truncates or splices a character. It sits in the board toplevel in the core clock domain, between the two TX sources and the pad.

---
 rtl/uart_tx_arbiter_if.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the two UART TX sources, the arbiter and the pad.
// The master side supplies the select and both serial lines; the slave
// side is the arbiter, which drives the muxed line and its status flags.
interface uart_tx_arbiter_if;
    logic i_sel;
    logic i_tx0;
    logic i_tx1;
    logic o_tx;
    logic o_active;
    logic o_pending;
    logic o_switched;

    modport master (
        output i_sel,
        output i_tx0,
        output i_tx1,
        input  o_tx,
        input  o_active,
        input  o_pending,
        input  o_switched
    );

    modport slave (
        input  i_sel,
        input  i_tx0,
        input  i_tx1,
        output o_tx,
        output o_active,
        output o_pending,
        output o_switched
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Frame-safe two-way arbiter for a shared UART TX pin. The selected source
// changes only after both lines have been continuously high for a full
// character time, so a switch can never cut or splice a character.
module uart_tx_arbiter #(
    parameter int unsigned CLK_FREQ_HZ = 25_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned IDLE_BITS   = 11
) (
    input logic              i_clk,
    input logic              i_rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int unsigned IdleCycles = IDLE_BITS * CLK_FREQ_HZ / BAUD;
    // Clamp keeps the declarations legal long enough for the check below to fire.
    localparam int unsigned CntW = (IdleCycles < 1) ? 1 : $clog2(IdleCycles + 1);
    localparam logic [CntW-1:0] IdleMax = CntW'(IdleCycles);

    if (IdleCycles < 1) begin : g_bad_params
        $error("uart_tx_arbiter: IDLE_BITS*CLK_FREQ_HZ/BAUD must be at least 1");
    end

    typedef enum logic [0:0] {StRun, StPend} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] idle0_q, idle1_q;
    logic            idle0, idle1;
    logic            tx_q, active_q, switched_q;
    logic            pending, do_switch;

    assign idle0 = (idle0_q == IdleMax);
    assign idle1 = (idle1_q == IdleMax);

    // Per-line run length of consecutive high samples, saturating at IdleMax.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idle0_q <= '0;
            idle1_q <= '0;
        end else begin
            if (!bus.i_tx0) begin
                idle0_q <= '0;
            end else if (!idle0) begin
                idle0_q <= idle0_q + CntW'(1);
            end
            if (!bus.i_tx1) begin
                idle1_q <= '0;
            end else if (!idle1) begin
                idle1_q <= idle1_q + CntW'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a request waits in StPend until withdrawn or both lines idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (bus.i_sel != active_q) state_d = StPend;
            end
            StPend: begin
                if ((bus.i_sel == active_q) || (idle0 && idle1)) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // FSM outputs; withdrawal takes priority over a coincident idle condition.
    always_comb begin
        pending   = (state_q == StPend);
        do_switch = (state_q == StPend) && (bus.i_sel != active_q) && idle0 && idle1;
    end

    // Registered pad output and status; o_tx uses the source active before any switch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_q       <= 1'b1;
            active_q   <= 1'b0;
            switched_q <= 1'b0;
        end else begin
            tx_q       <= active_q ? bus.i_tx1 : bus.i_tx0;
            switched_q <= do_switch;
            if (do_switch) active_q <= bus.i_sel;
        end
    end

    assign bus.o_tx       = tx_q;
    assign bus.o_active   = active_q;
    assign bus.o_pending  = pending;
    assign bus.o_switched = switched_q;

endmodule
